ltssm_link_ctrl: RTL and testbench
==================================

# ltssm_link_ctrl

Parametrised link-level LTSSM coordinator that joins the Tx and Rx sub-LTSSM handshakes into one link state, gates L0 entry on the LPIF state request and owns the negotiated link parameters. It sits between the LPIF adapter and the per-direction Tx/Rx LTSSM engines. Over the previous link controller it adds:
- a full Recovery path, including speed change up to MAX_GEN;
- per-substate timeout counters;
- per-lane detection masks for LANES lanes;
- deterministic, fully registered outputs.

## Interface
Parameters:
- DEVICETYPE, 0, 0 = downstream port, 1 = upstream port
- LANES, 16, number of physical lanes (1..32)
- MAX_GEN, 5, highest supported generation (1..7)
- TIMEOUT_CYCLES, 24000, substate timeout in clk cycles (≥4)

Ports:
- clk  in  1  single clock
- reset  in  1  reset; synchronous, active-high
- lpifStateRequest  in  4  0 = reset, 1 = active, 2 = retrain
- finishTx / finishRx  in  1  sub-LTSSM reports completion of current substate
- gotoTx / gotoRx  in  4  substate requested by that sub-LTSSM, valid with finish
- lanesDetectedIn  in  LANES  receiver-detect result mask
- writeLanesDetected  in  1  load lanesDetectedIn
- linkNumberIn  in  8  negotiated link number
- writeLinkNumber  in  1  load linkNumberIn
- rateIdIn  in  8  partner supported-rate mask; bit g-1 = Gen g
- writeRateId  in  1  load rateIdIn
- forceDetect  in  1  force return to detectQuiet
- linkUp  out  1  link trained
- GEN  out  3  current generation
- lanesActiveOut  out  LANES  registered detected-lane mask
- linkNumberOut  out  8  registered link number
- lpifStateStatus  out  4  0 = reset, 1 = active, 2 = retrain
- substateTx / substateRx  out  4  current substate driven to each engine (always equal)
- timeoutOut  out  1  one-cycle pulse when a timeout fires

## Operation
Substate encoding:
- 0 detectQuiet, 1 detectActive, 2 pollingActive, 3 pollingConfiguration
- 4 cfgLinkWidthStart, 5 cfgLinkWidthAccept, 6 cfgLanenumWait, 7 cfgLanenumAccept, 8 cfgComplete, 9 cfgIdle
- 10 L0
- 11 recRcvrLock, 12 recRcvrCfg, 13 recSpeed, 14 recIdle

Join rules:
- ALL: finishTx && finishRx && gotoTx == gotoRx == next.
- ANY: (finishTx && gotoTx == next) || (finishRx && gotoRx == next).
- RX: finishRx && gotoRx == next.

Forward transitions:
- detectQuiet → detectActive: RX.
- detectActive → pollingActive, pollingConfiguration → cfgLinkWidthStart, cfgComplete → cfgIdle: ALL.
- pollingActive → pollingConfiguration: ANY.
- cfgLinkWidthStart → Accept, cfgLanenumWait → Accept, cfgLanenumAccept → cfgComplete: RX.
- cfgLinkWidthAccept → cfgLanenumWait: Tx-only when DEVICETYPE = 0; ALL when DEVICETYPE = 1.

L0 entry and exit:
- cfgIdle with ALL(L0): set linkUp and hold in cfgIdle until lpifStateRequest = 1, then enter L0 with status 1.
- From L0: lpifStateRequest = 2, or RX(recRcvrLock), enters recRcvrLock with status 2.

Recovery:
- recRcvrLock → recRcvrCfg: ALL.
- recRcvrCfg: target = highest g ≤ MAX_GEN with rateId[g-1] set. If target > GEN, go to recSpeed on ALL; otherwise go to recIdle on ALL.
- recSpeed → recRcvrLock on ALL; GEN ← target in the same cycle.
- recIdle → L0 on ALL; status 1.

Global priority, highest first:
1. reset
2. forceDetect or lpifStateRequest = 0 while outside the reset LPIF state → detectQuiet, linkUp 0, status 0, GEN 1
3. ANY(detectQuiet) from any non-L0 state → detectQuiet
4. forward transition
5. timeout

Timeout:
- The counter clears on every substate change and is frozen in L0 and in cfgIdle while linkUp = 1.
- At TIMEOUT_CYCLES-1: detectQuiet goes to detectActive; every other state goes to detectQuiet with linkUp 0.
- timeoutOut pulses high for that one cycle.

Data registers:
- Each loads on its write strobe.
- The lane mask, link number and rateId registers clear to 0 on reset and on any return to detectQuiet. A write strobe asserted in the same cycle wins.

## Timing
- All outputs are registered. A substate change appears one cycle after the qualifying inputs are sampled.
- Reset values: substates 0, lpifStateStatus 0, linkUp 0, GEN 1, lanesActiveOut 0, linkNumberOut 0, timeoutOut 0.
- Reset mid-operation: outputs reach reset values on the next edge.
- finish/goto are sampled only in the current substate. Inputs that do not match a rule are ignored.
- Simultaneous timeout and forward transition: the forward transition wins.
- GEN updates in the same edge as the recSpeed → recRcvrLock transition.

## Structure
- Shared package ltssm_pkg holds:
  - substate and LPIF status localparams;
  - join-rule encoding;
  - a function gen_select(rateId, MAX_GEN).
- Sub-module ltssm_timeout_cnt: width $clog2(TIMEOUT_CYCLES), inputs clear/freeze, output expire pulse.

## Test plan
- Happy path, DEVICETYPE = 0: drive each join rule in order, then lpifStateRequest = 1 → L0 reached, linkUp = 1, status 1, GEN 1.
- Speed change: from L0 with rateId = 0x07 and MAX_GEN = 5, request retrain → recRcvrLock → recRcvrCfg → recSpeed → recRcvrLock; GEN becomes 3; the second pass goes through recIdle → L0 with status 1.
- Timeout: hold pollingActive with no finish for TIMEOUT_CYCLES → detectQuiet one cycle later, timeoutOut pulses once.
- Simultaneous events: in cfgLanenumWait, Rx requests Accept while Tx requests detectQuiet → detectQuiet and data registers cleared.
- Reset mid-Recovery and forceDetect in L0: all outputs at reset values within one cycle; lanesActiveOut is 0.

Source files
------------

// File: rtl/ltssm_pkg.sv
// ltssm_pkg: shared definitions for the link-level LTSSM coordinator.
//   substate_e   - 4-bit substate encoding driven to the Tx/Rx engines
//   LPIF_*       - LPIF state request/status codes
//   join_e       - how the Tx and Rx completions combine to qualify a move
//   join_ok()    - evaluates a join rule against the engine handshake
//   gen_select() - highest partner-supported generation not above max_gen
package ltssm_pkg;

  typedef enum logic [3:0] {
    DETECT_QUIET   = 4'd0,
    DETECT_ACTIVE  = 4'd1,
    POLLING_ACTIVE = 4'd2,
    POLLING_CONFIG = 4'd3,
    CFG_LW_START   = 4'd4,
    CFG_LW_ACCEPT  = 4'd5,
    CFG_LN_WAIT    = 4'd6,
    CFG_LN_ACCEPT  = 4'd7,
    CFG_COMPLETE   = 4'd8,
    CFG_IDLE       = 4'd9,
    L0             = 4'd10,
    REC_RCVR_LOCK  = 4'd11,
    REC_RCVR_CFG   = 4'd12,
    REC_SPEED      = 4'd13,
    REC_IDLE       = 4'd14
  } substate_e;

  localparam logic [3:0] LPIF_RESET   = 4'd0;
  localparam logic [3:0] LPIF_ACTIVE  = 4'd1;
  localparam logic [3:0] LPIF_RETRAIN = 4'd2;

  typedef enum logic [1:0] {
    JOIN_ALL = 2'd0,
    JOIN_ANY = 2'd1,
    JOIN_RX  = 2'd2,
    JOIN_TX  = 2'd3
  } join_e;

  function automatic logic join_ok(join_e rule, logic fin_tx, logic fin_rx,
                                   logic [3:0] goto_tx, logic [3:0] goto_rx,
                                   substate_e nxt);
    logic tx_hit;
    logic rx_hit;
    logic ok;
    tx_hit = fin_tx && (goto_tx == nxt);
    rx_hit = fin_rx && (goto_rx == nxt);
    case (rule)
      JOIN_ALL: ok = tx_hit && rx_hit;
      JOIN_ANY: ok = tx_hit || rx_hit;
      JOIN_RX:  ok = rx_hit;
      default:  ok = tx_hit;
    endcase
    return ok;
  endfunction

  // Gen1 is always supported, so it is the fallback when no usable bit is set.
  function automatic logic [2:0] gen_select(logic [7:0] rate_id, int unsigned max_gen);
    logic [2:0] g;
    g = 3'd1;
    for (int unsigned i = 1; i <= 7; i++) begin
      if (i <= max_gen && rate_id[i-1]) g = 3'(i);
    end
    return g;
  endfunction

endpackage

// File: rtl/ltssm_link_ctrl_if.sv
// ltssm_link_ctrl_if: handshake between the link coordinator and the
// per-direction Tx/Rx LTSSM engines.
//   finishTx/finishRx   - engine reports completion of its current substate
//   gotoTx/gotoRx       - substate the engine asks for, valid with finish
//   substateTx/Rx       - substate commanded to each engine
// master = coordinator side, slave = engine side.
interface ltssm_link_ctrl_if;
  logic       finishTx;
  logic       finishRx;
  logic [3:0] gotoTx;
  logic [3:0] gotoRx;
  logic [3:0] substateTx;
  logic [3:0] substateRx;

  modport master (
    input  finishTx, finishRx, gotoTx, gotoRx,
    output substateTx, substateRx
  );

  modport slave (
    output finishTx, finishRx, gotoTx, gotoRx,
    input  substateTx, substateRx
  );
endinterface

// File: rtl/ltssm_timeout_cnt.sv
// ltssm_timeout_cnt: per-substate timeout counter.
//   clk, rst    - clock, synchronous active-high reset
//   clear_i     - restart counting (substate is changing this edge)
//   freeze_i    - hold the count (states with no timeout)
//   expire_o    - high during the cycle the count sits at TIMEOUT_CYCLES-1
module ltssm_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 24000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic freeze_i,
  output logic expire_o
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Wrapping at LAST keeps the counter in range if a higher-priority event
  // holds the substate on the expiring cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) cnt_d = '0;
    else if (!freeze_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire_o = !freeze_i && (cnt_q == LAST);
endmodule

// File: rtl/ltssm_link_ctrl.sv
// ltssm_link_ctrl: joins the Tx/Rx sub-LTSSM handshakes into one link
// substate, gates L0 entry on the LPIF request and owns link parameters.
//   clk, reset            - clock, synchronous active-high reset
//   eng                   - engine handshake (finish/goto in, substate out)
//   lpifStateRequest      - 0 reset, 1 active, 2 retrain
//   lanesDetectedIn/write - receiver-detect mask load
//   linkNumberIn/write    - link number load
//   rateIdIn/write        - partner rate mask load (bit g-1 = Gen g)
//   forceDetect           - force return to detectQuiet
//   linkUp, GEN, lanesActiveOut, linkNumberOut, lpifStateStatus, timeoutOut
// All outputs come straight from registers.
module ltssm_link_ctrl
  import ltssm_pkg::*;
#(
  parameter int unsigned DEVICETYPE     = 0,
  parameter int unsigned LANES          = 16,
  parameter int unsigned MAX_GEN        = 5,
  parameter int unsigned TIMEOUT_CYCLES = 24000
) (
  input  logic             clk,
  input  logic             reset,
  ltssm_link_ctrl_if.master eng,
  input  logic [3:0]       lpifStateRequest,
  input  logic [LANES-1:0] lanesDetectedIn,
  input  logic             writeLanesDetected,
  input  logic [7:0]       linkNumberIn,
  input  logic             writeLinkNumber,
  input  logic [7:0]       rateIdIn,
  input  logic             writeRateId,
  input  logic             forceDetect,
  output logic             linkUp,
  output logic [2:0]       GEN,
  output logic [LANES-1:0] lanesActiveOut,
  output logic [7:0]       linkNumberOut,
  output logic [3:0]       lpifStateStatus,
  output logic             timeoutOut
);
  substate_e        state_q, state_d, tgt;
  logic             linkup_q, linkup_d;
  logic [3:0]       status_q, status_d;
  logic [2:0]       gen_q, gen_d, target;
  logic [LANES-1:0] lanes_q, lanes_d;
  logic [7:0]       linknum_q, linknum_d;
  logic [7:0]       rateid_q, rateid_d;
  logic             timeout_q, timeout_d;
  join_e            rule;
  logic             rule_hit, fwd, go_dq, abort, expire, freeze;

  assign target = gen_select(rateid_q, MAX_GEN);
  assign freeze = (state_q == L0) || (state_q == CFG_IDLE && linkup_q);

  always_comb begin
    rule   = JOIN_ALL;
    tgt    = DETECT_QUIET;
    case (state_q)
      DETECT_QUIET:   begin rule = JOIN_RX;  tgt = DETECT_ACTIVE;  end
      DETECT_ACTIVE:  begin rule = JOIN_ALL; tgt = POLLING_ACTIVE; end
      POLLING_ACTIVE: begin rule = JOIN_ANY; tgt = POLLING_CONFIG; end
      POLLING_CONFIG: begin rule = JOIN_ALL; tgt = CFG_LW_START;   end
      CFG_LW_START:   begin rule = JOIN_RX;  tgt = CFG_LW_ACCEPT;  end
      // A downstream port leads width acceptance from its own Tx side.
      CFG_LW_ACCEPT:  begin rule = (DEVICETYPE == 0) ? JOIN_TX : JOIN_ALL; tgt = CFG_LN_WAIT; end
      CFG_LN_WAIT:    begin rule = JOIN_RX;  tgt = CFG_LN_ACCEPT;  end
      CFG_LN_ACCEPT:  begin rule = JOIN_RX;  tgt = CFG_COMPLETE;   end
      CFG_COMPLETE:   begin rule = JOIN_ALL; tgt = CFG_IDLE;       end
      CFG_IDLE:       begin rule = JOIN_ALL; tgt = L0;             end
      L0:             begin rule = JOIN_RX;  tgt = REC_RCVR_LOCK;  end
      REC_RCVR_LOCK:  begin rule = JOIN_ALL; tgt = REC_RCVR_CFG;   end
      REC_RCVR_CFG:   begin rule = JOIN_ALL; tgt = (target > gen_q) ? REC_SPEED : REC_IDLE; end
      REC_SPEED:      begin rule = JOIN_ALL; tgt = REC_RCVR_LOCK;  end
      REC_IDLE:       begin rule = JOIN_ALL; tgt = L0;             end
      default:        begin rule = JOIN_ALL; tgt = DETECT_QUIET;   end
    endcase
    rule_hit = join_ok(rule, eng.finishTx, eng.finishRx, eng.gotoTx, eng.gotoRx, tgt);
  end

  always_comb begin
    state_d   = state_q;
    linkup_d  = linkup_q;
    status_d  = status_q;
    gen_d     = gen_q;
    timeout_d = 1'b0;
    go_dq     = 1'b0;
    fwd       = rule_hit;

    abort = forceDetect || (lpifStateRequest == LPIF_RESET && status_q != LPIF_RESET);

    if (abort) begin
      go_dq = 1'b1;
    end else if (state_q != L0 &&
                 join_ok(JOIN_ANY, eng.finishTx, eng.finishRx, eng.gotoTx, eng.gotoRx,
                         DETECT_QUIET)) begin
      go_dq = 1'b1;
    end else begin
      case (state_q)
        // ALL(L0) only arms linkUp; L0 itself waits for the LPIF active request.
        CFG_IDLE: begin
          if (linkup_q && lpifStateRequest == LPIF_ACTIVE) begin
            fwd      = 1'b1;
            state_d  = L0;
            status_d = LPIF_ACTIVE;
          end else if (rule_hit) begin
            linkup_d = 1'b1;
          end
        end
        L0: begin
          fwd = rule_hit || (lpifStateRequest == LPIF_RETRAIN);
          if (fwd) begin
            state_d  = REC_RCVR_LOCK;
            status_d = LPIF_RETRAIN;
          end
        end
        default: begin
          if (rule_hit) begin
            state_d = tgt;
            if (state_q == REC_SPEED) gen_d    = target;
            if (state_q == REC_IDLE)  status_d = LPIF_ACTIVE;
          end
        end
      endcase
      if (!fwd && expire) begin
        timeout_d = 1'b1;
        if (state_q == DETECT_QUIET) state_d = DETECT_ACTIVE;
        else                         go_dq   = 1'b1;
      end
    end

    if (go_dq) begin
      state_d  = DETECT_QUIET;
      linkup_d = 1'b0;
      status_d = LPIF_RESET;
      gen_d    = 3'd1;
    end

    // A write strobe in the same cycle as a return to detect keeps the new value.
    lanes_d   = writeLanesDetected ? lanesDetectedIn : (go_dq ? '0 : lanes_q);
    linknum_d = writeLinkNumber    ? linkNumberIn    : (go_dq ? '0 : linknum_q);
    rateid_d  = writeRateId        ? rateIdIn        : (go_dq ? '0 : rateid_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= DETECT_QUIET;
      linkup_q  <= 1'b0;
      status_q  <= LPIF_RESET;
      gen_q     <= 3'd1;
      lanes_q   <= '0;
      linknum_q <= '0;
      rateid_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      linkup_q  <= linkup_d;
      status_q  <= status_d;
      gen_q     <= gen_d;
      lanes_q   <= lanes_d;
      linknum_q <= linknum_d;
      rateid_q  <= rateid_d;
      timeout_q <= timeout_d;
    end
  end

  ltssm_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .rst      (reset),
    .clear_i  (state_d != state_q),
    .freeze_i (freeze),
    .expire_o (expire)
  );

  assign eng.substateTx  = state_q;
  assign eng.substateRx  = state_q;
  assign linkUp          = linkup_q;
  assign GEN             = gen_q;
  assign lanesActiveOut  = lanes_q;
  assign linkNumberOut   = linknum_q;
  assign lpifStateStatus = status_q;
  assign timeoutOut      = timeout_q;
endmodule

// File: tb/tb_ltssm_link_ctrl.sv
// Bench for ltssm_link_ctrl: directed scenarios followed by random traffic.
// Each driven cycle pushes the reference model's prediction into a queue;
// a monitor pops one entry after every rising edge and compares all outputs.
module tb_ltssm_link_ctrl;
  localparam int T     = 20;
  localparam int LANES = 16;
  localparam int MAXG  = 5;
  localparam int DT    = 0;

  logic             clk = 1'b0;
  logic             reset, forceDetect;
  logic [3:0]       lpifStateRequest;
  logic [LANES-1:0] lanesDetectedIn;
  logic             writeLanesDetected, writeLinkNumber, writeRateId;
  logic [7:0]       linkNumberIn, rateIdIn;
  logic             linkUp, timeoutOut;
  logic [2:0]       GEN;
  logic [LANES-1:0] lanesActiveOut;
  logic [7:0]       linkNumberOut;
  logic [3:0]       lpifStateStatus;

  ltssm_link_ctrl_if bif();

  ltssm_link_ctrl #(.DEVICETYPE(DT), .LANES(LANES), .MAX_GEN(MAXG), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .eng(bif),
    .lpifStateRequest(lpifStateRequest),
    .lanesDetectedIn(lanesDetectedIn), .writeLanesDetected(writeLanesDetected),
    .linkNumberIn(linkNumberIn), .writeLinkNumber(writeLinkNumber),
    .rateIdIn(rateIdIn), .writeRateId(writeRateId),
    .forceDetect(forceDetect),
    .linkUp(linkUp), .GEN(GEN), .lanesActiveOut(lanesActiveOut),
    .linkNumberOut(linkNumberOut), .lpifStateStatus(lpifStateStatus),
    .timeoutOut(timeoutOut)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Rule codes: 0 ALL, 1 ANY, 2 RX, 3 TX. Tables give the forward move out of
  // each substate; CFG_IDLE, L0 and REC_RCVR_CFG are handled separately.
  int nxt_tbl [15] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 11, 10};
  int rule_tbl[15] = '{2, 0, 1, 0, 2, (DT == 0) ? 3 : 0, 2, 2, 0, 0, 2, 0, 0, 0, 0};

  int               m_sub, m_stat, m_gen, m_age;
  bit               m_up, m_to;
  logic [LANES-1:0] m_lanes;
  logic [7:0]       m_link, m_rate;

  typedef struct {
    int sub; bit up; int gen; int stat;
    logic [LANES-1:0] lanes; logic [7:0] link; bit to;
  } exp_t;
  exp_t q[$];

  function automatic bit m_join(int rule, int nxt);
    bit t, r;
    t = bif.finishTx && (int'(bif.gotoTx) == nxt);
    r = bif.finishRx && (int'(bif.gotoRx) == nxt);
    case (rule)
      0: return t && r;
      1: return t || r;
      2: return r;
      default: return t;
    endcase
  endfunction

  function automatic int m_target();
    for (int g = MAXG; g >= 1; g--) if (m_rate[g-1]) return g;
    return 1;
  endfunction

  function automatic int m_intent();
    if (m_sub == 12) return (m_target() > m_gen) ? 13 : 14;
    if (m_sub == 9)  return 10;
    return nxt_tbl[m_sub];
  endfunction

  task automatic m_step();
    bit frozen, expire, dq, fwd, nup, nto;
    int nsub, nstat, ngen, n;
    if (reset) begin
      m_sub = 0; m_up = 0; m_stat = 0; m_gen = 1; m_age = 0; m_to = 0;
      m_lanes = '0; m_link = '0; m_rate = '0;
      return;
    end
    frozen = (m_sub == 10) || (m_sub == 9 && m_up);
    expire = !frozen && (m_age == T - 1);
    nsub = m_sub; nup = m_up; nstat = m_stat; ngen = m_gen; nto = 0; dq = 0; fwd = 0;
    if (forceDetect || (lpifStateRequest == 0 && m_stat != 0)) dq = 1;
    else if (m_sub != 10 && m_join(1, 0)) dq = 1;
    else begin
      if (m_sub == 9) begin
        if (m_up && lpifStateRequest == 1) begin fwd = 1; nsub = 10; nstat = 1; end
        else if (m_join(0, 10)) begin fwd = 1; nup = 1; end
      end else if (m_sub == 10) begin
        if (lpifStateRequest == 2 || m_join(2, 11)) begin fwd = 1; nsub = 11; nstat = 2; end
      end else if (m_sub == 12) begin
        n = (m_target() > m_gen) ? 13 : 14;
        if (m_join(0, n)) begin fwd = 1; nsub = n; end
      end else if (m_join(rule_tbl[m_sub], nxt_tbl[m_sub])) begin
        fwd = 1; nsub = nxt_tbl[m_sub];
        if (m_sub == 13) ngen = m_target();
        if (m_sub == 14) nstat = 1;
      end
      if (!fwd && expire) begin
        nto = 1;
        if (m_sub == 0) nsub = 1; else dq = 1;
      end
    end
    if (dq) begin nsub = 0; nup = 0; nstat = 0; ngen = 1; end
    m_lanes = writeLanesDetected ? lanesDetectedIn : (dq ? '0 : m_lanes);
    m_link  = writeLinkNumber    ? linkNumberIn    : (dq ? '0 : m_link);
    m_rate  = writeRateId        ? rateIdIn        : (dq ? '0 : m_rate);
    if (nsub != m_sub) m_age = 0;
    else if (!frozen)  m_age = (m_age == T - 1) ? 0 : m_age + 1;
    m_sub = nsub; m_up = nup; m_stat = nstat; m_gen = ngen; m_to = nto;
  endtask

  // ---------------- driver ----------------
  task automatic cyc();
    exp_t e;
    m_step();
    e.sub = m_sub; e.up = m_up; e.gen = m_gen; e.stat = m_stat;
    e.lanes = m_lanes; e.link = m_link; e.to = m_to;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic drv(bit ft, bit fr, logic [3:0] gt, logic [3:0] gr);
    bif.finishTx = ft; bif.finishRx = fr; bif.gotoTx = gt; bif.gotoRx = gr;
    cyc();
    reset = 0; forceDetect = 0;
    writeLanesDetected = 0; writeLinkNumber = 0; writeRateId = 0;
  endtask

  task automatic train();
    drv(0, 1, 0, 1);
    drv(1, 1, 2, 2);
    drv(1, 0, 3, 0);
    drv(1, 1, 4, 4);
    writeLanesDetected = 1; lanesDetectedIn = 16'hFFFF;
    writeLinkNumber = 1; linkNumberIn = 8'h05;
    drv(0, 1, 0, 5);
    drv(1, 0, 6, 0);
    drv(0, 1, 0, 7);
    drv(0, 1, 0, 8);
    drv(1, 1, 9, 9);
    drv(1, 1, 10, 10);
    chk("cfgidle_hold_sub", bif.substateTx, 9);
    chk("cfgidle_linkup", linkUp, 1);
    lpifStateRequest = 1;
    drv(0, 0, 0, 0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("substateTx", bif.substateTx, e.sub);
        chk("substateRx", bif.substateRx, e.sub);
        chk("linkUp", linkUp, e.up);
        chk("GEN", GEN, e.gen);
        chk("status", lpifStateStatus, e.stat);
        chk("lanes", lanesActiveOut, e.lanes);
        chk("linkNumber", linkNumberOut, e.link);
        chk("timeoutOut", timeoutOut, e.to);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, r;
    logic [3:0] it;
    reset = 1; forceDetect = 0; lpifStateRequest = 0;
    lanesDetectedIn = '0; linkNumberIn = '0; rateIdIn = '0;
    writeLanesDetected = 0; writeLinkNumber = 0; writeRateId = 0;
    bif.finishTx = 0; bif.finishRx = 0; bif.gotoTx = 0; bif.gotoRx = 0;
    m_sub = 0; m_up = 0; m_stat = 0; m_gen = 1; m_age = 0; m_to = 0;
    m_lanes = '0; m_link = '0; m_rate = '0;
    drv(0, 0, 0, 0);
    reset = 1;
    drv(0, 0, 0, 0);
    chk("rst_sub", bif.substateTx, 0);
    chk("rst_gen", GEN, 1);
    chk("rst_linkup", linkUp, 0);
    chk("rst_lanes", lanesActiveOut, 0);

    // Happy path to L0.
    train();
    chk("happy_sub", bif.substateTx, 10);
    chk("happy_linkup", linkUp, 1);
    chk("happy_status", lpifStateStatus, 1);
    chk("happy_gen", GEN, 1);
    chk("happy_lanes", lanesActiveOut, 16'hFFFF);

    // Speed change to Gen3 and back to L0.
    writeRateId = 1; rateIdIn = 8'h07;
    drv(0, 0, 0, 0);
    lpifStateRequest = 2;
    drv(0, 0, 0, 0);
    chk("retrain_sub", bif.substateTx, 11);
    chk("retrain_status", lpifStateStatus, 2);
    lpifStateRequest = 1;
    drv(1, 1, 12, 12);
    drv(1, 1, 13, 13);
    chk("speed_sub", bif.substateTx, 13);
    chk("speed_gen_before", GEN, 1);
    drv(1, 1, 11, 11);
    chk("speed_gen_after", GEN, 3);
    drv(1, 1, 12, 12);
    drv(1, 1, 14, 14);
    chk("recidle_sub", bif.substateTx, 14);
    drv(1, 1, 10, 10);
    chk("rec_l0_sub", bif.substateTx, 10);
    chk("rec_l0_status", lpifStateStatus, 1);

    // forceDetect in L0.
    forceDetect = 1;
    drv(0, 0, 0, 0);
    chk("force_sub", bif.substateTx, 0);
    chk("force_linkup", linkUp, 0);
    chk("force_gen", GEN, 1);
    chk("force_status", lpifStateStatus, 0);
    chk("force_lanes", lanesActiveOut, 0);
    chk("force_link", linkNumberOut, 0);

    // Timeout in pollingActive.
    drv(0, 1, 0, 1);
    drv(1, 1, 2, 2);
    n = 1;
    for (int k = 0; k < T + 5; k++) begin
      drv(0, 0, 0, 0);
      if (bif.substateTx == 4'd2) n++;
      else break;
    end
    chk("timeout_cycles", n, T);
    chk("timeout_sub", bif.substateTx, 0);
    chk("timeout_pulse", timeoutOut, 1);
    drv(0, 0, 0, 0);
    chk("timeout_pulse_end", timeoutOut, 0);

    // Rx accept racing Tx detectQuiet in cfgLanenumWait.
    drv(0, 1, 0, 1);
    drv(1, 1, 2, 2);
    drv(1, 0, 3, 0);
    drv(1, 1, 4, 4);
    writeLanesDetected = 1; lanesDetectedIn = 16'h00F0;
    writeLinkNumber = 1; linkNumberIn = 8'h2A;
    drv(0, 1, 0, 5);
    drv(1, 0, 6, 0);
    chk("lnwait_sub", bif.substateTx, 6);
    chk("lnwait_lanes", lanesActiveOut, 16'h00F0);
    drv(1, 1, 0, 7);
    chk("race_sub", bif.substateTx, 0);
    chk("race_lanes", lanesActiveOut, 0);
    chk("race_link", linkNumberOut, 0);

    // Reset mid-Recovery.
    train();
    lpifStateRequest = 2;
    drv(0, 0, 0, 0);
    lpifStateRequest = 1;
    drv(1, 1, 12, 12);
    chk("midrec_sub", bif.substateTx, 12);
    reset = 1;
    drv(0, 0, 0, 0);
    chk("midrst_sub", bif.substateTx, 0);
    chk("midrst_linkup", linkUp, 0);
    chk("midrst_status", lpifStateStatus, 0);
    chk("midrst_lanes", lanesActiveOut, 0);
    chk("midrst_link", linkNumberOut, 0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      it = 4'(m_intent());
      r = $urandom_range(0, 99);
      if (r < 70)      begin bif.gotoTx = it; bif.gotoRx = it; end
      else if (r < 76) begin bif.gotoTx = ($urandom_range(0, 1) != 0) ? 4'd0 : it; bif.gotoRx = it; end
      else             begin bif.gotoTx = 4'($urandom_range(0, 15)); bif.gotoRx = 4'($urandom_range(0, 15)); end
      bif.finishTx = ($urandom_range(0, 9) < 6);
      bif.finishRx = ($urandom_range(0, 9) < 6);
      r = $urandom_range(0, 99);
      lpifStateRequest = (r < 85) ? 4'd1 : (r < 97) ? 4'd2 : 4'd0;
      writeLanesDetected = ($urandom_range(0, 19) == 0);
      lanesDetectedIn    = LANES'($urandom());
      writeLinkNumber    = ($urandom_range(0, 19) == 0);
      linkNumberIn       = 8'($urandom_range(0, 255));
      writeRateId        = ($urandom_range(0, 19) == 0);
      rateIdIn           = 8'($urandom_range(0, 255));
      forceDetect        = ($urandom_range(0, 99) == 0);
      reset              = ($urandom_range(0, 199) == 0);
      cyc();
      reset = 0; forceDetect = 0;
      writeLanesDetected = 0; writeLinkNumber = 0; writeRateId = 0;
    end

    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
